// File: rtl/wav_ca_sched_pkg.sv
// wav_ca_sched_pkg -- shared types and constants for the CA scheduler.
//   state_e : scheduler FSM states
//   CA_*    : command/address opcodes driven on CA during the command cycle
package wav_ca_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_BURST = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam logic [5:0] CA_NOP = 6'd0;
    localparam logic [5:0] CA_RD  = 6'd2;
    localparam logic [5:0] CA_WR  = 6'd4;

endpackage

// File: rtl/wav_rr_arb2.sv
// wav_rr_arb2 -- two-way round-robin arbiter.
//   CK, RESET_N : clock, async active-low reset
//   req[1:0]    : requests (bit 0 = read, bit 1 = write)
//   advance     : a grant was accepted this cycle; move the pointer
//   grant[1:0]  : one-hot grant (combinational from req and pointer)
// A lone request always wins; on a tie the side not granted last wins.
// The pointer resets to read priority.
module wav_rr_arb2 (
    input  logic       CK,
    input  logic       RESET_N,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic pri_wr;  // 1: write wins a tie

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || !pri_wr))
            grant = 2'b01;
        else if (req[1])
            grant = 2'b10;
    end

    // After serving read, hand the tie to write, and vice versa.
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N)
            pri_wr <= 1'b0;
        else if (advance)
            pri_wr <= grant[0];
    end

endmodule

// File: rtl/wav_ca_sched.sv
// wav_ca_sched -- command/address scheduler for one outstanding read or
// write: arbitrate, issue one CS/CA command cycle, wait the latency, open
// the data window, then hold a turnaround gap before the next command.
//   CK, RESET_N                : clock, async active-low reset
//   rd_req_valid/rd_req_ready  : read requester handshake
//   wr_req_valid/wr_req_ready  : write requester handshake
//   CS, CA[5:0]                : command bus (CA=0 whenever CS=0)
//   rd_data_en / wr_data_en    : read capture / write drive windows
//   busy                       : FSM outside IDLE
//   rd_cnt, wr_cnt [15:0]      : saturating accepted-request counters,
//                                present only with WAV_CA_SCHED_STATS_EN
module wav_ca_sched
    import wav_ca_sched_pkg::*;
#(
    parameter int RD_LAT    = 22,
    parameter int WR_LAT    = 12,
    parameter int BURST_CYC = 8,
    parameter int TURN_GAP  = 2
) (
    input  logic        CK,
    input  logic        RESET_N,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic        wr_req_valid,
    output logic        wr_req_ready,
    output logic        CS,
    output logic [5:0]  CA,
    output logic        rd_data_en,
    output logic        wr_data_en,
    output logic        busy
`ifdef WAV_CA_SCHED_STATS_EN
    ,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
`endif
);

    localparam logic [7:0] RD_LAT8 = RD_LAT[7:0];
    localparam logic [7:0] WR_LAT8 = WR_LAT[7:0];
    localparam logic [7:0] BURST8  = BURST_CYC[7:0];
    localparam logic [7:0] GAP8    = TURN_GAP[7:0];

    state_e     state;
    logic [7:0] cnt;    // remaining cycles in WAIT/BURST/GAP, minus one
    logic       is_wr;  // current command is a write
    logic [7:0] lat;
    logic [1:0] grant;
    logic       idle;
    logic       hs;

    assign idle = (state == ST_IDLE);
    assign hs   = idle && (grant != 2'b00);
    assign lat  = is_wr ? WR_LAT8 : RD_LAT8;

    wav_rr_arb2 u_arb (
        .CK      (CK),
        .RESET_N (RESET_N),
        .req     ({wr_req_valid, rd_req_valid}),
        .advance (hs),
        .grant   (grant)
    );

    // Ready is gated by RESET_N so it drops the instant reset asserts.
    assign rd_req_ready = RESET_N && idle && grant[0];
    assign wr_req_ready = RESET_N && idle && grant[1];
    assign CS           = (state == ST_ISSUE);
    assign CA           = CS ? (is_wr ? CA_WR : CA_RD) : CA_NOP;
    assign rd_data_en   = (state == ST_BURST) && !is_wr;
    assign wr_data_en   = (state == ST_BURST) && is_wr;
    assign busy         = !idle;

    // The counter is loaded with (length - 1) on entry and the state exits
    // when it reads zero. WAIT is LAT-1 long, so it loads LAT-2; LAT=1
    // skips WAIT entirely and goes straight to BURST.
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
            is_wr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        state <= ST_ISSUE;
                        is_wr <= grant[1];
                    end
                end
                ST_ISSUE: begin
                    if (lat == 8'd1) begin
                        state <= ST_BURST;
                        cnt   <= BURST8 - 8'd1;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= lat - 8'd2;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 8'd0) begin
                        state <= ST_BURST;
                        cnt   <= BURST8 - 8'd1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_BURST: begin
                    if (cnt == 8'd0) begin
                        if (GAP8 == 8'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_GAP;
                            cnt   <= GAP8 - 8'd1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 8'd0)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WAV_CA_SCHED_STATS_EN
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (hs) begin
            if (grant[0] && (rd_cnt != 16'hFFFF))
                rd_cnt <= rd_cnt + 16'd1;
            if (grant[1] && (wr_cnt != 16'hFFFF))
                wr_cnt <= wr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wav_ca_sched.sv
// tb_wav_ca_sched -- self-checking bench for wav_ca_sched. Two instances:
// one with default parameters, one with minimal latencies (RD_LAT=1,
// WR_LAT=2, BURST_CYC=1, TURN_GAP=0). A select bit routes requester inputs
// to one instance and its outputs into a packed observation vector:
//   obs = {CS, CA[5:0], rd_data_en, wr_data_en, busy, rd_ready, wr_ready}
module tb_wav_ca_sched;

    logic CK = 1'b0;
    logic RESET_N;
    logic rd_v, wr_v;
    bit   sel;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   p_rd, p_wr, p_b, p_g;

    logic       rrdy0, wrdy0, cs0, rde0, wde0, busy0;
    logic [5:0] ca0;
    logic       rrdy1, wrdy1, cs1, rde1, wde1, busy1;
    logic [5:0] ca1;
    logic [11:0] obs;

    always #5 CK = ~CK;

    assign obs = sel ? {cs1, ca1, rde1, wde1, busy1, rrdy1, wrdy1}
                     : {cs0, ca0, rde0, wde0, busy0, rrdy0, wrdy0};

`ifdef WAV_CA_SCHED_STATS_EN
    logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif

    wav_ca_sched u_def (
        .CK           (CK),
        .RESET_N      (RESET_N),
        .rd_req_valid (rd_v && !sel),
        .rd_req_ready (rrdy0),
        .wr_req_valid (wr_v && !sel),
        .wr_req_ready (wrdy0),
        .CS           (cs0),
        .CA           (ca0),
        .rd_data_en   (rde0),
        .wr_data_en   (wde0),
        .busy         (busy0)
`ifdef WAV_CA_SCHED_STATS_EN
        ,
        .rd_cnt       (rdc0),
        .wr_cnt       (wrc0)
`endif
    );

    wav_ca_sched #(.RD_LAT(1), .WR_LAT(2), .BURST_CYC(1), .TURN_GAP(0)) u_min (
        .CK           (CK),
        .RESET_N      (RESET_N),
        .rd_req_valid (rd_v && sel),
        .rd_req_ready (rrdy1),
        .wr_req_valid (wr_v && sel),
        .wr_req_ready (wrdy1),
        .CS           (cs1),
        .CA           (ca1),
        .rd_data_en   (rde1),
        .wr_data_en   (wde1),
        .busy         (busy1)
`ifdef WAV_CA_SCHED_STATS_EN
        ,
        .rd_cnt       (rdc1),
        .wr_cnt       (wrc1)
`endif
    );

    task automatic select(input bit s);
        sel  = s;
        p_rd = s ? 1 : 22;
        p_wr = s ? 2 : 12;
        p_b  = s ? 1 : 8;
        p_g  = s ? 0 : 2;
    endtask

    // Returns at a falling edge with RESET_N just released.
    task automatic do_reset();
        @(posedge CK); #1;
        RESET_N = 1'b0; rd_v = 1'b0; wr_v = 1'b0;
        @(negedge CK); @(negedge CK);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; rd_v = 1'b1; wr_v = 1'b1;
        select(0);
        #12;
        n_chk++;
        if (obs !== 12'h000) begin
            n_fail++; $display("FAIL reset_def: got %h expected %h", obs, 12'h000);
        end
        select(1); #1;
        n_chk++;
        if (obs !== 12'h000) begin
            n_fail++; $display("FAIL reset_min: got %h expected %h", obs, 12'h000);
        end
        select(0);
        @(negedge CK); RESET_N = 1'b1; #1;
        n_chk++;  // read priority, handshake possible on first edge
        if (obs !== 12'h002) begin
            n_fail++; $display("FAIL reset_release_ready: got %h expected %h", obs, 12'h002);
        end
        @(negedge CK);
        n_chk++;
        if (obs !== 12'h844) begin
            n_fail++; $display("FAIL reset_first_cmd: got %h expected %h", obs, 12'h844);
        end
        rd_v = 1'b0; wr_v = 1'b0;
    endtask

    // Single request at cycle 0; valid stays high so ready reappears.
    task automatic test_single(input bit s, input bit wr, input int d_lo,
                               input int d_hi, input int rdy_at, input string nm);
        logic [11:0] exp;
        select(s);
        do_reset();
        if (wr) wr_v = 1'b1; else rd_v = 1'b1;
        #1;
        for (int c = 0; c <= rdy_at; c++) begin
            if (c > 0) @(negedge CK);
            exp        = '0;
            exp[11]    = (c == 1);
            exp[10:5]  = (c == 1) ? (wr ? 6'd4 : 6'd2) : 6'd0;
            exp[4]     = !wr && (c >= d_lo) && (c <= d_hi);
            exp[3]     = wr && (c >= d_lo) && (c <= d_hi);
            exp[2]     = (c >= 1) && (c < rdy_at);
            exp[1]     = !wr && ((c == 0) || (c == rdy_at));
            exp[0]     = wr && ((c == 0) || (c == rdy_at));
            n_chk++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b expected %b", nm, c, obs, exp);
            end
        end
        rd_v = 1'b0; wr_v = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [5:0] got [4];
        int n_cs = 0, n_hs = 0, ovl = 0;
        select(0);
        do_reset();
        rd_v = 1'b1; wr_v = 1'b1;
        for (int c = 0; c < 300 && n_cs < 4; c++) begin
            #1;
            if ((obs[1] && rd_v) || (obs[0] && wr_v)) n_hs++;
            if (obs[11]) begin got[n_cs] = obs[10:5]; n_cs++; end
            if (obs[4] && obs[3]) ovl++;
            @(negedge CK);
        end
        rd_v = 1'b0; wr_v = 1'b0;
        n_chk++;
        if (n_cs !== 4) begin
            n_fail++; $display("FAIL rr_timeout: got %0d commands expected %0d", n_cs, 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (got[i] !== ((i % 2 == 0) ? 6'd2 : 6'd4)) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got[i],
                             (i % 2 == 0) ? 2 : 4);
                end
            end
        end
        n_chk++;
        if (ovl !== 0) begin
            n_fail++; $display("FAIL rr_overlap: got %0d overlap cycles expected 0", ovl);
        end
        n_chk++;
        if (n_cs !== n_hs) begin
            n_fail++; $display("FAIL rr_cs_per_grant: got %0d CS expected %0d", n_cs, n_hs);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit found = 1'b0;
        select(0);
        do_reset();
        rd_v = 1'b1; #1;
        n_chk++;
        if (obs[1] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_ready: got %b expected 1", obs[1]);
        end
        for (int c = 1; c <= 25; c++) begin
            @(negedge CK);
            if (c == 1) rd_v = 1'b0;
        end
        n_chk++;
        if (obs[4] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_in_burst: got %b expected 1", obs[4]);
        end
        RESET_N = 1'b0; rd_v = 1'b1; wr_v = 1'b1;
        #1;
        n_chk++;
        if (obs !== 12'h000) begin
            n_fail++; $display("FAIL midrst_outputs: got %h expected %h", obs, 12'h000);
        end
        @(negedge CK); RESET_N = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge CK);
            if (obs[11]) found = 1'b1;
        end
        n_chk++;
        if (!found || obs[10:5] !== 6'd2) begin
            n_fail++; $display("FAIL midrst_first_ca: got found=%b ca=%0d expected ca=2", found, obs[10:5]);
        end
        rd_v = 1'b0; wr_v = 1'b0;
    endtask

    // Reference model: a command accepted at the end of cycle h occupies
    // cycles h+1 .. h+LAT+BURST+GAP; data window at offsets LAT..LAT+BURST-1
    // from the command cycle. Ready only when idle, by round-robin rule.
    task automatic test_random(input bit s, input int ncyc, input string nm);
        logic [11:0] exp;
        int  cyc = 0, cmd_cyc = 0, idle_at = 0, off, lat;
        bit  m_wr = 1'b0, pri_wr = 1'b0, g_rd, g_wr;
        int  errs = 0;
        select(s);
        do_reset();
        rd_v = ($urandom_range(1) == 1);
        wr_v = ($urandom_range(1) == 1);
        #1;
        for (int k = 0; k < ncyc; k++) begin
            exp = '0;
            if (cyc < idle_at) begin
                off       = cyc - cmd_cyc;
                lat       = m_wr ? p_wr : p_rd;
                exp[11]   = (off == 0);
                exp[10:5] = (off == 0) ? (m_wr ? 6'd4 : 6'd2) : 6'd0;
                exp[4]    = !m_wr && (off >= lat) && (off < lat + p_b);
                exp[3]    = m_wr && (off >= lat) && (off < lat + p_b);
                exp[2]    = 1'b1;
            end else begin
                g_rd   = rd_v && (!wr_v || !pri_wr);
                g_wr   = wr_v && !g_rd;
                exp[1] = g_rd;
                exp[0] = g_wr;
            end
            n_chk++;
            if (obs !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 5)
                    $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, obs, exp);
            end
            g_rd = exp[1];
            g_wr = exp[0];
            @(posedge CK); #1;
            cyc++;
            if (g_rd || g_wr) begin
                cmd_cyc = cyc;
                m_wr    = g_wr;
                idle_at = cyc + (g_wr ? p_wr : p_rd) + p_b + p_g;
                pri_wr  = g_rd;
            end
            if (g_rd) rd_v = ($urandom_range(1) == 1);
            else if (!rd_v) rd_v = ($urandom_range(2) == 0);
            if (g_wr) wr_v = ($urandom_range(1) == 1);
            else if (!wr_v) wr_v = ($urandom_range(2) == 0);
            @(negedge CK);
        end
        rd_v = 1'b0; wr_v = 1'b0;
    endtask

`ifdef WAV_CA_SCHED_STATS_EN
    // Raise one request, hold until accepted, then let the command drain.
    task automatic do_req(input bit wr);
        bit ok = 1'b0;
        if (wr) wr_v = 1'b1; else rd_v = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (wr ? wrdy1 : rrdy1) ok = 1'b1;
            else @(negedge CK);
        end
        @(posedge CK); #1;
        rd_v = 1'b0; wr_v = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++; $display("FAIL stats_handshake_timeout: got no ready expected ready");
        end
        repeat (5) @(negedge CK);
    endtask

    task automatic test_stats();
        select(1);
        do_reset();
        n_chk++;
        if (rdc1 !== 16'd0 || wrc1 !== 16'd0) begin
            n_fail++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", rdc1, wrc1);
        end
        do_req(0); do_req(0); do_req(1); do_req(0); do_req(1);
        n_chk++;
        if (rdc1 !== 16'd3 || wrc1 !== 16'd2) begin
            n_fail++; $display("FAIL stats_count: got %0d/%0d expected 3/2", rdc1, wrc1);
        end
        force u_min.rd_cnt = 16'hFFFF;
        @(negedge CK);
        release u_min.rd_cnt;
        do_req(0);
        n_chk++;
        if (rdc1 !== 16'hFFFF || wrc1 !== 16'd2) begin
            n_fail++; $display("FAIL stats_saturate: got %h/%0d expected ffff/2", rdc1, wrc1);
        end
    endtask
`endif

    initial begin
        RESET_N = 1'b0; rd_v = 1'b0; wr_v = 1'b0;
        select(0);
        test_reset();
        test_single(0, 1'b0, 23, 30, 33, "single_read");
        test_single(0, 1'b1, 13, 20, 23, "single_write");
        test_single(1, 1'b0, 2, 2, 3, "min_lat_read");
        test_single(1, 1'b1, 3, 3, 4, "min_lat_write");
        test_round_robin();
        test_reset_mid_burst();
        test_random(0, 3000, "random_default");
        test_random(1, 2000, "random_min");
`ifdef WAV_CA_SCHED_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
